// File: rtl/food_placer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : food_placer                                                   |
// | Purpose  : picks a free interior grid cell from LFSR draws; falls back   |
// |            to a raster scan when the draw budget runs out.               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module food_placer #(
  parameter int                X_W       = 7,
  parameter int                Y_W       = 6,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int                MAX_TRIES = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [X_W-1:0] frame_x_inside_grid,
  input  logic [Y_W-1:0] frame_y_inside_grid,
  input  logic [X_W-1:0] number_x_grid,
  input  logic [Y_W-1:0] number_y_grid,
  input  logic           req,
  output logic [X_W-1:0] occ_x,
  output logic [Y_W-1:0] occ_y,
  input  logic           occ_hit,
  output logic [X_W-1:0] food_x,
  output logic [Y_W-1:0] food_y,
  output logic           valid,
  output logic           fail,
  output logic           busy
);

  localparam int TRIES_W = (MAX_TRIES < 1) ? 1 : $clog2(MAX_TRIES + 1);
  localparam logic [TRIES_W-1:0] c_max_tries = TRIES_W'(MAX_TRIES);

  // Right-shifting Fibonacci form: tap t sits at bit index LFSR_W - t.
  localparam logic [LFSR_W-1:0] c_taps =
      (LFSR_W == 8)  ? LFSR_W'(32'h0000_001D) :
      (LFSR_W == 24) ? LFSR_W'(32'h0000_0087) :
      (LFSR_W == 32) ? LFSR_W'(32'hC000_0401) :
                       LFSR_W'(32'h0000_002D);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAW  = 2'd1,
    S_CHECK = 2'd2,
    S_SCAN  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LFSR_W-1:0]  r_lfsr;
  logic [LFSR_W-1:0]  w_lfsr_nxt;
  logic [TRIES_W-1:0] r_tries;
  logic [TRIES_W-1:0] w_tries_nxt;
  logic [TRIES_W-1:0] w_tries_inc;
  logic [X_W-1:0]     r_cand_x, w_cand_x_nxt;
  logic [Y_W-1:0]     r_cand_y, w_cand_y_nxt;
  logic [X_W-1:0]     r_scan_x, w_scan_x_nxt;
  logic [Y_W-1:0]     r_scan_y, w_scan_y_nxt;
  logic [X_W-1:0]     r_food_x, w_food_x_nxt;
  logic [Y_W-1:0]     r_food_y, w_food_y_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_fail, w_fail_nxt;

  logic signed [X_W:0] w_span_x;
  logic signed [Y_W:0] w_span_y;
  logic                w_empty;
  logic [X_W-1:0]      w_rx;
  logic [Y_W-1:0]      w_ry;
  logic                w_draw_ok;
  logic [X_W-1:0]      w_last_x;
  logic [Y_W-1:0]      w_last_y;
  logic                w_scan_last;

  assign w_span_x = $signed({1'b0, number_x_grid}) - $signed({1'b0, frame_x_inside_grid})
                  - $signed({1'b0, frame_x_inside_grid});
  assign w_span_y = $signed({1'b0, number_y_grid}) - $signed({1'b0, frame_y_inside_grid})
                  - $signed({1'b0, frame_y_inside_grid});
  assign w_empty  = w_span_x[X_W] || (w_span_x == '0) || w_span_y[Y_W] || (w_span_y == '0);

  assign w_rx      = r_lfsr[X_W-1:0];
  assign w_ry      = r_lfsr[X_W+Y_W-1:X_W];
  // Spans are known positive whenever DRAW is reachable, so unsigned compare is safe.
  assign w_draw_ok = ({1'b0, w_rx} < $unsigned(w_span_x)) && ({1'b0, w_ry} < $unsigned(w_span_y));

  assign w_last_x    = number_x_grid - frame_x_inside_grid - X_W'(1);
  assign w_last_y    = number_y_grid - frame_y_inside_grid - Y_W'(1);
  assign w_scan_last = (r_scan_x == w_last_x) && (r_scan_y == w_last_y);

  assign w_lfsr_nxt  = {^(r_lfsr & c_taps), r_lfsr[LFSR_W-1:1]};
  assign w_tries_inc = r_tries + TRIES_W'(1);

  always_comb begin
    w_state_nxt  = r_state;
    w_tries_nxt  = r_tries;
    w_cand_x_nxt = r_cand_x;
    w_cand_y_nxt = r_cand_y;
    w_scan_x_nxt = frame_x_inside_grid;
    w_scan_y_nxt = frame_y_inside_grid;
    w_food_x_nxt = r_food_x;
    w_food_y_nxt = r_food_y;
    w_valid_nxt  = 1'b0;
    w_fail_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          if (w_empty) begin
            w_fail_nxt = 1'b1;
          end else begin
            w_tries_nxt = '0;
            w_state_nxt = S_DRAW;
          end
        end
      end
      S_DRAW: begin
        if (w_draw_ok) begin
          w_cand_x_nxt = frame_x_inside_grid + w_rx;
          w_cand_y_nxt = frame_y_inside_grid + w_ry;
          w_state_nxt  = S_CHECK;
        end else begin
          w_tries_nxt = w_tries_inc;
          if (w_tries_inc == c_max_tries) begin
            w_state_nxt = S_SCAN;
          end
        end
      end
      S_CHECK: begin
        if (!occ_hit) begin
          w_food_x_nxt = r_cand_x;
          w_food_y_nxt = r_cand_y;
          w_valid_nxt  = 1'b1;
          w_state_nxt  = S_IDLE;
        end else begin
          w_tries_nxt = w_tries_inc;
          w_state_nxt = (w_tries_inc == c_max_tries) ? S_SCAN : S_DRAW;
        end
      end
      S_SCAN: begin
        w_scan_x_nxt = r_scan_x;
        w_scan_y_nxt = r_scan_y;
        if (!occ_hit) begin
          w_food_x_nxt = r_scan_x;
          w_food_y_nxt = r_scan_y;
          w_valid_nxt  = 1'b1;
          w_state_nxt  = S_IDLE;
        end else if (w_scan_last) begin
          w_fail_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_scan_x == w_last_x) begin
          w_scan_x_nxt = frame_x_inside_grid;
          w_scan_y_nxt = r_scan_y + Y_W'(1);
        end else begin
          w_scan_x_nxt = r_scan_x + X_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_lfsr   <= SEED;
      r_tries  <= '0;
      r_cand_x <= '0;
      r_cand_y <= '0;
      r_scan_x <= '0;
      r_scan_y <= '0;
      r_food_x <= frame_x_inside_grid;
      r_food_y <= w_last_y;
      r_valid  <= 1'b0;
      r_fail   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_lfsr   <= w_lfsr_nxt;
      r_tries  <= w_tries_nxt;
      r_cand_x <= w_cand_x_nxt;
      r_cand_y <= w_cand_y_nxt;
      r_scan_x <= w_scan_x_nxt;
      r_scan_y <= w_scan_y_nxt;
      r_food_x <= w_food_x_nxt;
      r_food_y <= w_food_y_nxt;
      r_valid  <= w_valid_nxt;
      r_fail   <= w_fail_nxt;
    end
  end

  always_comb begin
    occ_x = r_food_x;
    occ_y = r_food_y;
    case (r_state)
      S_CHECK: begin
        occ_x = r_cand_x;
        occ_y = r_cand_y;
      end
      S_SCAN: begin
        occ_x = r_scan_x;
        occ_y = r_scan_y;
      end
      default: ;
    endcase
  end

  assign food_x = r_food_x;
  assign food_y = r_food_y;
  assign valid  = r_valid;
  assign fail   = r_fail;
  assign busy   = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_food_placer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_food_placer                                                |
// | Purpose  : scoreboard bench for food_placer with an LFSR reference model |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_food_placer;

  localparam int MAX_TRIES = 15;
  localparam int K_VALID   = 1;
  localparam int K_FAIL    = 2;

  typedef struct {
    int kind;
    int x;
    int y;
    int cyc;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       req;
  logic [6:0] frame_x, number_x, occ_x, food_x;
  logic [5:0] frame_y, number_y, occ_y, food_y;
  logic       occ_hit, valid, fail, busy;

  int g_fx, g_fy, g_nx, g_ny, mode;
  int cur_fx, cur_fy;
  int n_checks, n_pass, n_events, busy_cnt;
  bit range_on, prev_valid;
  logic [15:0] m_lfsr;
  exp_t q[$];
  exp_t mon_e;

  assign frame_x  = g_fx[6:0];
  assign frame_y  = g_fy[5:0];
  assign number_x = g_nx[6:0];
  assign number_y = g_ny[5:0];

  function automatic bit occupied(input int x, input int y);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return !(x == 3 && y == 2);
  endfunction

  assign occ_hit = occupied(int'(occ_x), int'(occ_y));

  food_placer dut (
    .clk                 (clk),
    .reset               (reset),
    .frame_x_inside_grid (frame_x),
    .frame_y_inside_grid (frame_y),
    .number_x_grid       (number_x),
    .number_y_grid       (number_y),
    .req                 (req),
    .occ_x               (occ_x),
    .occ_y               (occ_y),
    .occ_hit             (occ_hit),
    .food_x              (food_x),
    .food_y              (food_y),
    .valid               (valid),
    .fail                (fail),
    .busy                (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] adv(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  always @(posedge clk) m_lfsr <= reset ? 16'hACE1 : adv(m_lfsr);

  task automatic check_eq(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: draw loop with range/occupancy rejections, then raster scan.
  task automatic predict(input logic [15:0] l0, output exp_t e, output int pre);
    logic [15:0] l;
    int tries, sx, sy, rx, ry;
    l = l0; tries = 0; pre = 0;
    e.cyc = 0; e.kind = K_FAIL; e.x = cur_fx; e.y = cur_fy;
    sx = g_nx - 2 * g_fx;
    sy = g_ny - 2 * g_fy;
    if (sx <= 0 || sy <= 0) return;
    while (tries < MAX_TRIES) begin
      rx = int'(l[6:0]);
      ry = int'(l[12:7]);
      l = adv(l);
      e.cyc++;
      if (rx < sx && ry < sy) begin
        l = adv(l);
        e.cyc++;
        if (!occupied(g_fx + rx, g_fy + ry)) begin
          e.kind = K_VALID; e.x = g_fx + rx; e.y = g_fy + ry;
          cur_fx = e.x; cur_fy = e.y;
          return;
        end
      end
      tries++;
    end
    pre = e.cyc;
    for (int y = g_fy; y < g_ny - g_fy; y++) begin
      for (int x = g_fx; x < g_nx - g_fx; x++) begin
        e.cyc++;
        if (!occupied(x, y)) begin
          e.kind = K_VALID; e.x = x; e.y = y;
          cur_fx = x; cur_fy = y;
          return;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      busy_cnt   = 0;
      prev_valid = 1'b0;
    end else begin
      if (valid || fail) begin
        n_events++;
        check_eq("valid_fail_exclusive", int'(valid && fail), 0);
        check_eq("occ_eq_food_idle", int'(occ_x == food_x && occ_y == food_y), 1);
        if (valid) check_eq("valid_width", int'(prev_valid), 0);
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_event: valid=%0b fail=%0b food=(%0d,%0d), no event expected",
                   valid, fail, food_x, food_y);
        end else begin
          mon_e = q.pop_front();
          check_eq("event_kind", valid ? K_VALID : K_FAIL, mon_e.kind);
          check_eq("food_x", int'(food_x), mon_e.x);
          check_eq("food_y", int'(food_y), mon_e.y);
          check_eq("busy_cycles", busy_cnt, mon_e.cyc);
          if (range_on && valid)
            check_eq("food_in_interior",
                     int'(food_x >= 1 && food_x <= 38 && food_y >= 1 && food_y <= 28), 1);
        end
        busy_cnt = 0;
      end
      if (busy) busy_cnt++;
      prev_valid = valid;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    req   = 1'b0;
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    cur_fx = g_fx;
    cur_fy = g_ny - g_fy - 1;
    check_eq("rst_food_x", int'(food_x), cur_fx);
    check_eq("rst_food_y", int'(food_y), cur_fy);
    check_eq("rst_valid", int'(valid), 0);
    check_eq("rst_fail", int'(fail), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_lfsr", int'(dut.r_lfsr), 32'hACE1);
    reset = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge where valid/fail is seen.
  task automatic do_req();
    exp_t e;
    int   pre;
    bit   done;
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    predict(m_lfsr, e, pre);
    q.push_back(e);
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (valid || fail) begin
        done = 1'b1;
        break;
      end
    end
    check_eq("completion", int'(done), 1);
  endtask

  initial begin
    exp_t e;
    int   pre, ev0;
    n_checks = 0; n_pass = 0; n_events = 0; busy_cnt = 0;
    range_on = 1'b0; prev_valid = 1'b0; mode = 0;
    reset = 1'b1; req = 1'b0;
    g_fx = 1; g_fy = 1; g_nx = 40; g_ny = 30;

    // Random placement on 40x30, back-to-back requests accepted while valid is high.
    do_reset();
    range_on = 1'b1;
    @(negedge clk);
    repeat (1000) do_req();
    range_on = 1'b0;

    // 6x5 fully occupied, then one free cell at (3,2).
    g_nx = 6; g_ny = 5; mode = 1;
    do_reset();
    @(negedge clk);
    do_req();
    do_req();
    mode = 2;
    do_req();
    do_req();

    // Empty interior in x.
    g_nx = 2; g_ny = 30; mode = 0;
    do_reset();
    @(negedge clk);
    do_req();
    do_req();

    // Reset in the middle of a scan drops the request.
    g_nx = 6; g_ny = 5; mode = 1;
    do_reset();
    @(negedge clk);
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    predict(m_lfsr, e, pre);
    q.push_back(e);
    for (int i = 0; i < pre + 4; i++) @(negedge clk);
    check_eq("busy_mid_scan", int'(busy), 1);
    ev0 = n_events;
    do_reset();
    repeat (30) @(negedge clk);
    check_eq("no_event_after_reset", n_events, ev0);

    // A req pulsed while busy is dropped.
    g_nx = 40; g_ny = 30; mode = 0;
    do_reset();
    @(negedge clk);
    ev0 = n_events;
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    predict(m_lfsr, e, pre);
    q.push_back(e);
    @(negedge clk);
    check_eq("busy_during_req", int'(busy), 1);
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (60) @(negedge clk);
    check_eq("single_valid", n_events, ev0 + 1);
    check_eq("idle_after", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/food_placer.md
FOOD_PLACER -- requirements
Module: food_placer

Interface
REQ-001 Parameter X_W, default 7, width of grid x coordinates.
REQ-002 Parameter Y_W, default 6, width of grid y coordinates.
REQ-003 Parameter LFSR_W, default 16, LFSR width; SHALL be at least X_W+Y_W.
REQ-004 Parameter SEED, default 16'hACE1, LFSR reset value; SHALL be nonzero.
REQ-005 Parameter MAX_TRIES, default 15, number of random attempts before the block falls back to scan mode.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 frame_x_inside_grid  in  X_W  border width in cells, left and right.
REQ-009 frame_y_inside_grid  in  Y_W  border width in cells, top and bottom.
REQ-010 number_x_grid / number_y_grid  in  X_W / Y_W  grid size in cells.
REQ-011 req  in  1  request a new food position; sampled only in IDLE.
REQ-012 occ_x / occ_y  out  X_W / Y_W  cell currently being queried against the snake body.
REQ-013 occ_hit  in  1  combinational reply for (occ_x, occ_y) in the same cycle; 1 = occupied.
REQ-014 food_x / food_y  out  X_W / Y_W  registered, current food position.
REQ-015 valid  out  1  one-cycle pulse when food_x/food_y has been updated.
REQ-016 fail  out  1  one-cycle pulse when no free interior cell exists.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 Interior bounds: x spans frame_x_inside_grid..number_x_grid-frame_x_inside_grid-1 inclusive; y spans the same way using the y inputs.
REQ-019 span_x = number_x_grid - 2*frame_x_inside_grid and span_y = number_y_grid - 2*frame_y_inside_grid SHALL be computed signed, one bit wider than the inputs; a span <= 0 means the interior is empty.
REQ-020 The Fibonacci LFSR (taps 16,14,13,11 for LFSR_W=16) SHALL advance every cycle outside reset, in all states.
REQ-021 Raw draw: rx = lfsr[X_W-1:0] and ry = lfsr[X_W+Y_W-1:X_W]; no modulo is used.
REQ-022 States: IDLE, DRAW, CHECK, SCAN.
REQ-023 IDLE transitions:
  - req=1 with an empty interior: fail pulses the next cycle and the block stays in IDLE.
  - req=1 otherwise: tries is cleared and the block goes to DRAW.
REQ-024 DRAW, in-range draw (rx<span_x and ry<span_y): cand = (frame_x+rx, frame_y+ry) and the block goes to CHECK.
REQ-025 DRAW, out-of-range draw: tries increments; at tries==MAX_TRIES the block goes to SCAN, otherwise it stays in DRAW.
REQ-026 CHECK: occ = cand.
  - occ_hit=0: food <= cand, valid pulses the next cycle, and the block returns to IDLE.
  - occ_hit=1: tries increments; the block goes to SCAN if tries==MAX_TRIES, otherwise to DRAW.
REQ-027 SCAN entry: the scan position starts at (frame_x, frame_y); raster order is x first, then y.
REQ-028 SCAN, each cycle: occ = scan position.
  - occ_hit=0: food <= scan position, valid pulses, and the block returns to IDLE.
  - occ_hit=1: the position advances.
REQ-029 SCAN end: occ_hit=1 at the last interior cell pulses fail, leaves food unchanged, and returns to IDLE.
REQ-030 In IDLE and DRAW, occ_x/occ_y SHALL equal food_x/food_y.
REQ-031 The tries counter is $clog2(MAX_TRIES+1) bits wide and counts both range rejections and occupied hits.
REQ-032 req is ignored while busy=1; no request is queued.
REQ-033 A req in the cycle valid or fail is high SHALL be accepted, because the block is already in IDLE.
REQ-034 valid and fail SHALL never be high in the same cycle.
REQ-035 Worst-case latency from req to valid/fail SHALL be at most 2*MAX_TRIES + span_x*span_y + 2 cycles.

Reset
REQ-036 With reset=1 at a clock edge, the block SHALL load:
  - state IDLE, lfsr = SEED, tries = 0;
  - valid = 0, fail = 0, busy = 0;
  - food_x = frame_x_inside_grid;
  - food_y = number_y_grid - frame_y_inside_grid - 1.
REQ-037 Reset SHALL take priority in any state, including mid-CHECK or mid-SCAN; the request in progress is dropped and no valid or fail pulse follows.

Verification
REQ-038 Reset, frame (1,1), grid 40x30 -> food=(1,28), valid=0, fail=0, busy=0, and lfsr=16'hACE1 on the first cycle after reset.
REQ-039 occ_hit tied to 0, 1000 reqs -> every valid has food inside x 1..38 and y 1..28, valid is exactly one cycle wide, and results match the LFSR reference model.
REQ-040 Grid 6x5, frame 1, occ_hit tied to 1 -> MAX_TRIES attempts, then 12 scan cycles, then one fail pulse; food unchanged and no valid.
REQ-041 Grid 6x5, frame 1, every cell occupied except (3,2) -> valid with food=(3,2).
REQ-042 number_x_grid=2, frame_x=1, req -> fail on the next cycle and busy stays 0.
REQ-043 reset asserted mid-SCAN -> reset values of REQ-036 next cycle; a req pulsed while busy -> no second valid.
